debug_ring_arbiter: RTL and testbench

//  Packet-granular round-robin arbiter that shares one debug-ring egress
//  (dii_flit stream) between INPUTS requesters, e.g. ring-forward and local

---
 rtl/debug_ring_arbiter_pkg.sv | 12 +
 rtl/dii_package.sv | 10 +
 rtl/debug_ring_arbiter_if.sv | 28 ++
 rtl/debug_ring_rr_pick.sv | 26 ++
 rtl/debug_ring_arbiter.sv | 105 ++++++++++
 tb/tb_debug_ring_arbiter.sv | 249 ++++++++++++++++++++++++
 6 files changed

// File: rtl/debug_ring_arbiter_pkg.sv
// rtl/debug_ring_arbiter_pkg.sv - index helpers shared by the ring arbiters
package debug_ring_arbiter_pkg;

   function automatic int idx_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   function automatic int rr_next(input int cur, input int n);
      return (cur + 1) % n;
   endfunction

endpackage

// File: rtl/dii_package.sv
// rtl/dii_package.sv - debug interconnect flit type shared across ring blocks
package dii_package;

   typedef struct packed {
      logic        valid;
      logic        last;
      logic [15:0] data;
   } dii_flit;

endpackage

// File: rtl/debug_ring_arbiter_if.sv
// rtl/debug_ring_arbiter_if.sv - requester/egress bundle of the ring arbiter
interface debug_ring_arbiter_if #(
   parameter int INPUTS = 2
);
   import dii_package::*;
   import debug_ring_arbiter_pkg::*;

   localparam int GW = idx_width(INPUTS);

   dii_flit [INPUTS-1:0] dii_in;
   logic    [INPUTS-1:0] dii_in_ready;
   dii_flit              dii_out;
   logic                 dii_out_ready;
   logic    [GW-1:0]     grant_id;
   logic                 busy;
   logic                 overlength;

   modport slave (
      input  dii_in, dii_out_ready,
      output dii_in_ready, dii_out, grant_id, busy, overlength
   );

   modport master (
      output dii_in, dii_out_ready,
      input  dii_in_ready, dii_out, grant_id, busy, overlength
   );

endinterface

// File: rtl/debug_ring_rr_pick.sv
// rtl/debug_ring_rr_pick.sv - combinational rotate-priority picker
module debug_ring_rr_pick
   import debug_ring_arbiter_pkg::*;
#(
   parameter int INPUTS = 2,
   parameter int GW     = idx_width(INPUTS)
) (
   input  logic [INPUTS-1:0] req,
   input  logic [GW-1:0]     ptr,
   output logic              gnt_valid,
   output logic [GW-1:0]     gnt_idx
);

   // Scan from the far end so the request closest to ptr overwrites last.
   always_comb begin
      gnt_valid = 1'b0;
      gnt_idx   = '0;
      for (int k = INPUTS - 1; k >= 0; k--) begin
         if (req[(int'(ptr) + k) % INPUTS]) begin
            gnt_valid = 1'b1;
            gnt_idx   = GW'((int'(ptr) + k) % INPUTS);
         end
      end
   end

endmodule

// File: rtl/debug_ring_arbiter.sv
// rtl/debug_ring_arbiter.sv - packet-granular round-robin arbiter for one ring egress
module debug_ring_arbiter #(
   parameter int INPUTS      = 2,
   parameter int MAX_PKT_LEN = 16
) (
   input logic                 clk,
   input logic                 rst_n,
   debug_ring_arbiter_if.slave bus
);
   import dii_package::*;
   import debug_ring_arbiter_pkg::*;

   localparam int GW = idx_width(INPUTS);
   localparam int CW = $clog2(MAX_PKT_LEN + 2);

   localparam logic [0:0] IDLE   = 1'b0;
   localparam logic [0:0] LOCKED = 1'b1;

   localparam logic [CW-1:0] CNT_MAX = CW'(MAX_PKT_LEN);
   localparam logic [CW-1:0] CNT_SAT = CW'(MAX_PKT_LEN + 1);

   logic [0:0]        state;
   logic [GW-1:0]     rr_ptr;
   logic [GW-1:0]     grant_q;
   logic [CW-1:0]     pkt_cnt;
   dii_flit           out_q;
   logic              ovl_q;

   logic [INPUTS-1:0] req;
   logic              pick_valid;
   logic [GW-1:0]     pick_idx;
   logic [GW-1:0]     cur_grant;
   logic              grant_live;
   logic              can_load;
   logic              accept;
   dii_flit           sel_flit;

   always_comb begin
      req = '0;
      for (int i = 0; i < INPUTS; i++) begin
         req[i] = bus.dii_in[i].valid;
      end
   end

   debug_ring_rr_pick #(
      .INPUTS (INPUTS),
      .GW     (GW)
   ) u_rr_pick (
      .req       (req),
      .ptr       (rr_ptr),
      .gnt_valid (pick_valid),
      .gnt_idx   (pick_idx)
   );

   // rst_n gates can_load so no requester sees ready while reset is held.
   always_comb begin
      can_load   = rst_n && (!out_q.valid || bus.dii_out_ready);
      cur_grant  = (state == LOCKED) ? grant_q : pick_idx;
      grant_live = (state == LOCKED) || pick_valid;
      sel_flit   = bus.dii_in[cur_grant];
      accept     = can_load && grant_live && sel_flit.valid;
      bus.dii_in_ready = '0;
      for (int i = 0; i < INPUTS; i++) begin
         bus.dii_in_ready[i] = can_load && grant_live && (cur_grant == GW'(i));
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= IDLE;
         rr_ptr  <= '0;
         grant_q <= '0;
         pkt_cnt <= '0;
         out_q   <= '0;
         ovl_q   <= 1'b0;
      end else begin
         ovl_q <= accept && (pkt_cnt == CNT_MAX);
         if (accept) begin
            out_q <= sel_flit;
            if (state == IDLE) begin
               grant_q <= cur_grant;
            end
            if (sel_flit.last) begin
               state   <= IDLE;
               rr_ptr  <= GW'(rr_next(int'(cur_grant), INPUTS));
               pkt_cnt <= '0;
            end else begin
               // Overlength is only reported; the packet keeps the grant.
               state <= LOCKED;
               if (pkt_cnt != CNT_SAT) begin
                  pkt_cnt <= pkt_cnt + CW'(1);
               end
            end
         end else if (bus.dii_out_ready) begin
            out_q.valid <= 1'b0;
         end
      end
   end

   assign bus.dii_out    = out_q;
   assign bus.grant_id   = grant_q;
   assign bus.busy       = (state == LOCKED);
   assign bus.overlength = ovl_q;

endmodule

// File: tb/tb_debug_ring_arbiter.sv
// tb/tb_debug_ring_arbiter.sv - scoreboard bench for debug_ring_arbiter
module tb_debug_ring_arbiter;
   import dii_package::*;

   localparam int INPUTS  = 2;
   localparam int MAX_LEN = 4;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   debug_ring_arbiter_if #(.INPUTS(INPUTS)) bus();

   debug_ring_arbiter #(
      .INPUTS      (INPUTS),
      .MAX_PKT_LEN (MAX_LEN)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   int n_checks = 0;
   int n_errors = 0;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   dii_flit src_q[INPUTS][$];
   dii_flit exp_q[$];
   logic    rdy_pat[$];
   int      fire_cyc[$];

   int          cycle = 0;
   int          accepted[INPUTS];
   logic [INPUTS-1:0] in_fire;
   logic [INPUTS-1:0] rdy_seen;
   int          stalls = 0;
   int          ovl_pulses = 0;
   int          busy_cycles = 0;
   int          owner_bad = 0;
   int          watch_owner = -1;
   int          ready0_bad = 0;
   bit          watch_ready0 = 1'b0;
   logic [15:0] ovl_data = '0;
   bit          prev_stall = 1'b0;
   dii_flit     prev_out;

   function automatic dii_flit mk(input int src, input int pkt, input int idx, input bit last);
      dii_flit f;
      f.valid = 1'b1;
      f.last  = last;
      f.data  = {src[3:0], pkt[3:0], idx[7:0]};
      return f;
   endfunction

   task automatic add_pkt(input int src, input int pkt, input int len);
      for (int i = 0; i < len; i++) src_q[src].push_back(mk(src, pkt, i, i == len - 1));
   endtask

   task automatic exp_pkt(input int src, input int pkt, input int len);
      for (int i = 0; i < len; i++) exp_q.push_back(mk(src, pkt, i, i == len - 1));
   endtask

   task automatic drive();
      for (int i = 0; i < INPUTS; i++) begin
         bus.dii_in[i] = (src_q[i].size() != 0) ? src_q[i][0] : '0;
      end
   endtask

   // Observe at negedge, then advance sources and drive just after posedge.
   task automatic step();
      dii_flit e;
      @(negedge clk);
      if (bus.dii_out.valid && bus.dii_out_ready) begin
         if (exp_q.size() == 0) begin
            check_eq("egress_extra", {15'd0, bus.dii_out.last, bus.dii_out.data}, 32'hffff_ffff);
         end else begin
            e = exp_q.pop_front();
            check_eq("egress", {15'd0, bus.dii_out.last, bus.dii_out.data}, {15'd0, e.last, e.data});
         end
         fire_cyc.push_back(cycle);
      end
      if (prev_stall) check_eq("stall_hold", {14'd0, bus.dii_out}, {14'd0, prev_out});
      prev_stall = bus.dii_out.valid && !bus.dii_out_ready;
      prev_out   = bus.dii_out;
      if (prev_stall) stalls++;
      if (bus.overlength) begin
         ovl_pulses++;
         ovl_data = bus.dii_out.data;
      end
      if (bus.busy) busy_cycles++;
      if (watch_owner >= 0 && bus.busy && int'(bus.grant_id) != watch_owner) owner_bad++;
      if (watch_ready0 && bus.dii_in_ready[0]) ready0_bad++;
      rdy_seen = bus.dii_in_ready;
      for (int i = 0; i < INPUTS; i++) in_fire[i] = bus.dii_in[i].valid && bus.dii_in_ready[i];
      @(posedge clk);
      #1;
      cycle++;
      for (int i = 0; i < INPUTS; i++) begin
         if (in_fire[i]) begin
            e = src_q[i].pop_front();
            accepted[i]++;
         end
      end
      drive();
      bus.dii_out_ready = (rdy_pat.size() != 0) ? rdy_pat.pop_front() : 1'b1;
   endtask

   function automatic int pending();
      return exp_q.size() + src_q[0].size() + src_q[1].size();
   endfunction

   task automatic run_drain(input string tag, input int budget);
      int n = 0;
      while (pending() != 0 && n < budget) begin
         step();
         n++;
      end
      check_eq({tag, "_drained"}, pending(), 0);
   endtask

   initial begin
      int base;
      int n;
      bit added;

      for (int i = 0; i < INPUTS; i++) accepted[i] = 0;
      bus.dii_in        = '0;
      bus.dii_out_ready = 1'b1;
      rst_n             = 1'b0;

      // Reset held with every requester valid.
      add_pkt(0, 0, 2);
      add_pkt(1, 0, 2);
      drive();
      repeat (3) step();
      check_eq("rst_out_valid", bus.dii_out.valid, 0);
      check_eq("rst_in_ready", bus.dii_in_ready, 0);
      check_eq("rst_busy", bus.busy, 0);
      check_eq("rst_grant_id", bus.grant_id, 0);
      check_eq("rst_overlength", bus.overlength, 0);
      rst_n = 1'b1;
      exp_pkt(0, 0, 2);
      exp_pkt(1, 0, 2);
      step();
      check_eq("first_grant_ready", rdy_seen, 2'b01);
      run_drain("t1", 50);

      // Continuous 3-flit packets on both inputs.
      fire_cyc.delete();
      for (int p = 1; p <= 3; p++) begin
         add_pkt(0, p, 3);
         add_pkt(1, p, 3);
         exp_pkt(0, p, 3);
         exp_pkt(1, p, 3);
      end
      run_drain("t2", 100);
      check_eq("t2_flits", fire_cyc.size(), 18);
      if (fire_cyc.size() == 18) check_eq("t2_no_gap", fire_cyc[17] - fire_cyc[0], 17);

      // Input 0 arrives while input 1 holds a 4-flit packet.
      fire_cyc.delete();
      base = accepted[1];
      add_pkt(1, 4, 4);
      exp_pkt(1, 4, 4);
      exp_pkt(0, 4, 2);
      ready0_bad   = 0;
      watch_ready0 = 1'b1;
      added        = 1'b0;
      n            = 0;
      while (pending() != 0 && n < 60) begin
         step();
         n++;
         if (!added && accepted[1] - base >= 2) begin
            add_pkt(0, 4, 2);
            drive();
            added = 1'b1;
         end
         if (accepted[1] - base >= 4) watch_ready0 = 1'b0;
      end
      watch_ready0 = 1'b0;
      check_eq("t3_drained", pending(), 0);
      check_eq("t3_ready0_locked_out", ready0_bad, 0);
      check_eq("t3_flits", fire_cyc.size(), 6);
      if (fire_cyc.size() == 6) check_eq("t3_handover", fire_cyc[4] - fire_cyc[3], 1);

      // Egress backpressure mid-packet.
      stalls = 0;
      add_pkt(0, 5, 4);
      exp_pkt(0, 5, 4);
      rdy_pat = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
      run_drain("t4", 50);
      check_eq("t4_stalls", stalls, 2);

      // Overlength packet with MAX_PKT_LEN=4.
      ovl_pulses  = 0;
      busy_cycles = 0;
      owner_bad   = 0;
      watch_owner = 1;
      add_pkt(1, 6, 18);
      exp_pkt(1, 6, 18);
      run_drain("t5", 100);
      watch_owner = -1;
      check_eq("t5_ovl_pulses", ovl_pulses, 1);
      check_eq("t5_ovl_at_flit", ovl_data[7:0], 4);
      check_eq("t5_busy_cycles", busy_cycles, 17);
      check_eq("t5_owner_held", owner_bad, 0);
      check_eq("t5_pkt_cnt_clear", dut.pkt_cnt, 0);
      check_eq("t5_busy_end", bus.busy, 0);

      // Asynchronous reset in the middle of a packet.
      add_pkt(1, 7, 3);
      exp_pkt(1, 7, 3);
      n = fire_cyc.size();
      for (int k = 0; k < 20 && fire_cyc.size() == n; k++) step();
      check_eq("t6_first_out", fire_cyc.size() - n, 1);
      check_eq("t6_busy_before", bus.busy, 1);
      #2;
      rst_n = 1'b0;
      #1;
      check_eq("t6_async_valid", bus.dii_out.valid, 0);
      check_eq("t6_async_ready", bus.dii_in_ready, 0);
      check_eq("t6_async_busy", bus.busy, 0);
      check_eq("t6_async_grant", bus.grant_id, 0);
      exp_q.delete();
      for (int i = 0; i < INPUTS; i++) src_q[i].delete();
      drive();
      prev_stall = 1'b0;
      repeat (2) step();
      rst_n = 1'b1;
      check_eq("t6_state_idle", dut.state, 0);
      check_eq("t6_rr_ptr", dut.rr_ptr, 0);
      add_pkt(1, 8, 1);
      add_pkt(0, 8, 1);
      exp_pkt(0, 8, 1);
      exp_pkt(1, 8, 1);
      run_drain("t6", 30);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
